uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive front end for the SoC's UART. Oversamples the asynchronous `uart_rx` pin at 16x, deserialises 8N1 frames (optional even parity), and buffers bytes in a small FIFO. The core reads bytes through a valid/ready port in place of loading its UART buffer directly. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface

**Parameters**
- `CLK_DIV`, default 54: clk cycles per oversample tick; baud = f_clk / (16·CLK_DIV); legal range 2–65535.
- `FIFO_DEPTH`, default 8: byte entries; must be a power of 2, from 2 to 256.

**Ports** (clock and reset first)
- `clk` input, 1: single system clock; every flop is on its rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `uart_rx` input, 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` output, 8: FIFO head byte; meaningful only while `rx_valid` is 1.
- `rx_valid` output, 1: FIFO is not empty.
- `rx_ready` input, 1: consumer accepts; a pop occurs on a cycle with `rx_valid && rx_ready`.
- `rx_count` output, $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `frame_err` output, 1: 1-cycle pulse when a stop bit is sampled as 0.
- `parity_err` output, 1: 1-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- `overrun` output, 1: 1-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

- **Input path**
  - `uart_rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - A tick counter wraps at CLK_DIV-1 and produces a 1-cycle `tick` strobe.
- **FSM states:** IDLE, START, DATA, PARITY (only when compiled in), STOP.
- **IDLE:** on a synchronised falling edge (previous 1, current 0), clear the sample counter and go to START. The tick counter restarts at the edge.
- **START:** at sample 8, if the line is 1 the start is a glitch → IDLE. If the line is 0, reset the sample counter → DATA.
- **DATA:** sample at sample-count 8 of each 16-tick bit; shift LSB first. After bit 7, go to PARITY, or to STOP when parity is compiled out.
- **PARITY:** sample at mid-bit; error if XOR(data, bit) ≠ 0 → STOP.
- **STOP:** sample at mid-bit, then always → IDLE immediately (no wait for bit end), so back-to-back frames are accepted.
  - Stop = 0: pulse `frame_err` and discard the byte.
  - Stop = 1 with a parity error: pulse `parity_err` and discard the byte.
  - Otherwise: push the byte.
- **Break / line held low:** after a framing error, IDLE requires a 1→0 edge. A held-low line therefore produces exactly one `frame_err` and no further frames.
- **FIFO:** circular, read and write pointers each one bit wider than the address.
  - Push when full with no pop that cycle: byte dropped, `overrun` pulse.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
  - Push and pop in the same cycle while empty: only the push happens, because `rx_valid` was 0.
  - Pointers wrap modulo FIFO_DEPTH.
- **`rx_data`:** combinational read of the head entry.

## Timing

- **Reset values:**
  - FSM = IDLE; counters, pointers and shift register = 0; synchronisers = 1.
  - `rx_valid` = 0, `rx_count` = 0, `rx_data` = 0, all error pulses = 0.
- **Reset mid-frame:** the partial byte is lost, FIFO contents are cleared, and no error pulse is produced. After release, the block needs a fresh 1→0 edge.
- **Pin to FSM:** 2 clk cycles of synchroniser latency.
- **Stop sample to output:** byte written on the stop mid-sample edge. `rx_valid` and `rx_count` update on the next cycle, 1 cycle after the push.
- **Error pulses:** asserted for exactly the one cycle following the stop mid-sample.
- **Pop:** `rx_count` decrements and the head advances on the cycle after a `rx_valid && rx_ready` edge. A consumer holding `rx_ready` high can drain one byte per cycle.
- **Sample accuracy:** mid-bit sampling tolerates ±3% baud mismatch.

## Configuration

- **`UART_RX_PARITY_EN` defined:** frames are 8E1. The PARITY state exists, and `parity_err` is driven as described in Operation.
- **Not defined:** frames are 8N1. The PARITY state and its logic are absent, and `parity_err` is constant 0.

## Test plan

- **Single byte:** CLK_DIV=4, send 0x55 (8N1) with `rx_ready`=0 → `rx_valid`=1, `rx_data`=0x55 and `rx_count`=1 one cycle after the stop mid-sample; no error pulses.
- **Back-to-back drain:** send 0xA3, 0x00, 0xFF back-to-back, then hold `rx_ready`=1 → pops in order over 3 consecutive cycles; `rx_valid` then 0 and `rx_count`=0.
- **Glitch and framing error:**
  - Low pulse of 5 ticks → no frame.
  - Frame 0x3C with stop=0 → one `frame_err` pulse, nothing pushed.
  - Line then held low for 40 bit times → no further pulses.
- **Overrun with simultaneous pop:** FIFO_DEPTH=8, send 9 bytes with `rx_ready`=0 → `rx_count`=8, one `overrun` on the 9th byte, head still byte 1. Then time a pop to coincide with a 10th push → count stays 8 and the 10th byte is stored.
- **Reset mid-frame:** assert `rst`=0 during data bit 4, release, then send 0x81 → exactly one entry, 0x81; no `frame_err`.
- **Parity (`UART_RX_PARITY_EN`):** 0x07 with parity bit 1 → pushed. 0x07 with parity bit 0 → one `parity_err` pulse, not pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a valid/ready byte FIFO.
// Frames are 8N1 by default and 8E1 when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 54,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DIV_W  = $clog2(CLK_DIV);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t            state, state_nx;
  logic              rx_sync_p0, rx_sync_p1, rx_prev_p2;
  logic [1:0]        warm;
  logic              rx_line, fall, tick, mid_start, mid_bit;
  logic [DIV_W-1:0]  div_cnt;
  logic [3:0]        samp_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              div_clr, samp_clr, shift_en, push_req, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              par_ld, par_bad, perr_d;
`endif
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, pop, push;

  // Stage p0/p1: synchroniser. p2: edge history, held low until the synchroniser
  // carries the real pin so a line that is low at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b0;
      warm       <= 2'b00;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      warm       <= {warm[0], 1'b1};
      rx_prev_p2 <= rx_sync_p1 & warm[1];
    end
  end

  assign rx_line   = rx_sync_p1;
  assign fall      = rx_prev_p2 & ~rx_sync_p1;
  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Start is checked on the 8th tick after the edge; every later bit 16 ticks on.
  assign mid_start = tick && (samp_cnt == 4'd7);
  assign mid_bit   = tick && (samp_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (fall) state_nx = START;
      START:  if (mid_start) state_nx = rx_line ? IDLE : DATA;
      DATA:   if (mid_bit && (bit_cnt == 3'd7)) state_nx = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid_bit) state_nx = STOP;
`endif
      STOP:   if (mid_bit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    div_clr  = 1'b0;
    samp_clr = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ld   = 1'b0;
    perr_d   = 1'b0;
`endif
    case (state)
      IDLE: if (fall) begin
        div_clr  = 1'b1;
        samp_clr = 1'b1;
      end
      START:  if (mid_start) samp_clr = 1'b1;
      DATA:   if (mid_bit) shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid_bit) par_ld = 1'b1;
      STOP: if (mid_bit) begin
        if (!rx_line)     ferr_d   = 1'b1;
        else if (par_bad) perr_d   = 1'b1;
        else              push_req = 1'b1;
      end
`else
      STOP: if (mid_bit) begin
        if (!rx_line) ferr_d   = 1'b1;
        else          push_req = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      samp_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      div_cnt <= (div_clr || tick) ? '0 : div_cnt + DIV_W'(1);
      if (samp_clr)  samp_cnt <= 4'd0;
      else if (tick) samp_cnt <= samp_cnt + 4'd1;
      if (samp_clr)      bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_reg <= {rx_line, shift_reg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_ld) par_bad <= ^{shift_reg, rx_line};
      parity_err <= perr_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // FIFO: a push while full is only kept when a pop frees the head that same edge.
  assign rx_count = wr_ptr - rd_ptr;
  assign rx_valid = (rx_count != '0);
  assign full     = (rx_count == PTR_W'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push     = push_req && (!full || pop);
  assign rx_data  = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= shift_reg;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= push_req && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames from tasks, scoreboard queue of expected
// bytes, negedge monitor that checks every popped byte and counts error pulses.
module tb_uart_rx_fifo;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
  localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Stop bit centre, in ticks after the start edge.
  localparam int STOP_TICKS = 8 + 16 * (9 + PAR);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       frame_err, parity_err, overrun;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         n_checks = 0, n_errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
  int         got_ferr = 0, got_perr = 0, got_ovr = 0;
  int         t_start = 0, t_valid = -1;
  logic       valid_q = 1'b0;
  bit         rnd_done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte must be the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (frame_err)  got_ferr++;
      if (parity_err) got_perr++;
      if (overrun)    got_ovr++;
      if (rx_valid && !valid_q) t_valid = cyc;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got %02h expected no byte", rx_data);
        end else begin
          check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    valid_q = rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR != 0) send_bit(par_b);
    send_bit(stop_b);
  endtask

  // Reference outcome of one frame given the current FIFO fill.
  task automatic expect_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input bit pop_with);
    if (!stop_b) exp_ferr++;
    else if ((PAR != 0) && ((^d ^ par_b) == 1'b1)) exp_perr++;
    else if ((exp_q.size() >= DEPTH) && !pop_with) exp_ovr++;
    else exp_q.push_back(d);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    expect_frame(d, 1'b1, even_par(d), 1'b0);
    send_frame(d, 1'b1, even_par(d));
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_count"}, 32'(rx_count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, 32'(rx_data), 32'(exp_q[0]));
    check({tag, "_frame_err"}, 32'(got_ferr), 32'(exp_ferr));
    check({tag, "_parity_err"}, 32'(got_perr), 32'(exp_perr));
    check({tag, "_overrun"}, 32'(got_ovr), 32'(exp_ovr));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    rx_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_count", 32'(rx_count), 0);
    check("reset_data", 32'(rx_data), 0);
    check("reset_pulses", 32'({frame_err, parity_err, overrun}), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    rx_byte(8'h55);
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("single");
    lat = t_valid - t_start;
    check("single_latency", 32'((lat >= STOP_TICKS * CLK_DIV + 1) && (lat <= STOP_TICKS * CLK_DIV + 4)), 1);
    drain(4);
    check_idle("single_drained");

    rx_byte(8'hA3);
    rx_byte(8'h00);
    rx_byte(8'hFF);
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("b2b");
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_drain_valid", 32'(rx_valid), 1);
      check("b2b_drain_count", 32'(rx_count), 32'(3 - i));
    end
    @(negedge clk);
    check("b2b_empty_valid", 32'(rx_valid), 0);
    check("b2b_empty_count", 32'(rx_count), 0);
    @(posedge clk);
    #1 rx_ready = 1'b0;
    check_idle("b2b_done");

    uart_rx = 1'b0;
    repeat (5 * CLK_DIV) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    check_idle("glitch");

    expect_frame(8'h3C, 1'b0, even_par(8'h3C), 1'b0);
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    repeat (40 * BIT) @(posedge clk);
    #1;
    check_idle("break");
    uart_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    check_idle("break_release");

    for (int i = 0; i < 9; i++) rx_byte(8'($urandom));
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("overrun_full");
    d = 8'($urandom);
    expect_frame(d, 1'b1, even_par(d), 1'b1);
    fork
      send_frame(d, 1'b1, even_par(d));
      begin
        repeat (STOP_TICKS * CLK_DIV + 2) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("overrun_pop_push");
    drain(12);
    check_idle("overrun_drained");

    rx_byte(8'($urandom));
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("pre_reset");
    fork
      send_frame(8'hF0, 1'b1, even_par(8'hF0));
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    repeat (2 * BIT) @(posedge clk);
    #1;
    check_idle("post_reset");
    @(negedge clk);
    check("post_reset_data", 32'(rx_data), 0);
    @(posedge clk);
    #1;
    rx_byte(8'h81);
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("after_reset");
    drain(3);

    fork
      begin
        for (int i = 0; i < 6; i++) rx_byte(8'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rx_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain(10);
    check_idle("random");

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    check_idle("parity");
    drain(3);
`endif

    check_idle("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
